// File: rtl/boot_rom_patch_pkg.sv
// Shared types, config-map offsets and the ROM image for the patchable boot ROM.
package boot_rom_patch_pkg;

    localparam logic [7:0] PADDR_OFFSET    = 8'h00;
    localparam logic [7:0] PDATA_LO_OFFSET = 8'h04;
    localparam logic [7:0] PDATA_HI_OFFSET = 8'h08;
    localparam logic [7:0] LOCK_OFFSET     = 8'hFC;

    typedef struct packed {
        logic        en;
        logic [29:0] waddr;
        logic [63:0] data;
    } patch_entry_t;

    // Boot image: upper half tags the word index, lower half is its complement.
    function automatic logic [31:0] rom_word32(input logic [15:0] idx);
        return {idx ^ 16'hB007, ~idx};
    endfunction

endpackage

// File: rtl/boot_rom_patch_table.sv
// Patch register file with sticky lock, config read/write port and
// lowest-index-wins match encoder against the requested word index.
module boot_rom_patch_table
    import boot_rom_patch_pkg::*;
#(
    parameter int unsigned ROM_ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_PATCH      = 4,
    parameter int unsigned WIDX_W         = ROM_ADDR_WIDTH - 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  i_cfg_req,
    input  logic                  i_cfg_we,
    input  logic [7:0]            i_cfg_addr,
    input  logic [31:0]           i_cfg_wdata,
    output logic [31:0]           o_cfg_rdata,
    output logic                  o_cfg_rvalid,
    input  logic [WIDX_W-1:0]     i_widx,
    input  logic                  i_test_mode,
    output logic                  o_hit,
    output logic [DATA_WIDTH-1:0] o_data
);

    localparam int unsigned BYTE_BITS = $clog2(DATA_WIDTH / 8);
    localparam int unsigned STRIDE    = (DATA_WIDTH == 64) ? 16 : 8;

    logic                  r_lock;
    logic                  r_cfg_rvalid;
    logic [31:0]           r_cfg_rdata;
    logic                  w_wr;
    logic                  w_en    [NUM_PATCH];
    logic [WIDX_W-1:0]     w_waddr [NUM_PATCH];
    logic [DATA_WIDTH-1:0] w_pdata [NUM_PATCH];
    logic [31:0]           w_rdata;
    logic [63:0]           w_pd64;
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_data;

    // Lock is sampled as registered, so the write that sets it still sees it clear.
    assign w_wr = i_cfg_req & i_cfg_we & ~r_lock;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PATCH; gi++) begin : g_entry
            localparam logic [7:0] BASE = 8'(gi * STRIDE);
            logic              r_en;
            logic [WIDX_W-1:0] r_waddr;
            logic [31:0]       r_data_lo;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_en      <= 1'b0;
                    r_waddr   <= '0;
                    r_data_lo <= '0;
                end else if (w_wr) begin
                    if (i_cfg_addr == BASE + PADDR_OFFSET) begin
                        r_en    <= i_cfg_wdata[0];
                        r_waddr <= i_cfg_wdata[ROM_ADDR_WIDTH-1:BYTE_BITS];
                    end
                    if (i_cfg_addr == BASE + PDATA_LO_OFFSET) begin
                        r_data_lo <= i_cfg_wdata;
                    end
                end
            end

            assign w_en[gi]    = r_en;
            assign w_waddr[gi] = r_waddr;

            if (DATA_WIDTH == 64) begin : g_hi
                logic [31:0] r_data_hi;
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        r_data_hi <= '0;
                    end else if (w_wr && i_cfg_addr == BASE + PDATA_HI_OFFSET) begin
                        r_data_hi <= i_cfg_wdata;
                    end
                end
                assign w_pdata[gi] = {r_data_hi, r_data_lo};
            end else begin : g_nohi
                assign w_pdata[gi] = r_data_lo;
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lock <= 1'b0;
        end else if (w_wr && i_cfg_addr == LOCK_OFFSET && i_cfg_wdata[0]) begin
            r_lock <= 1'b1;
        end
    end

    always_comb begin
        w_rdata = '0;
        w_pd64  = '0;
        if (i_cfg_addr == LOCK_OFFSET) begin
            w_rdata[0] = r_lock;
        end
        for (int i = 0; i < int'(NUM_PATCH); i++) begin
            if (i_cfg_addr == 8'(i * STRIDE) + PADDR_OFFSET) begin
                w_rdata = '0;
                w_rdata[ROM_ADDR_WIDTH-1:BYTE_BITS] = w_waddr[i];
                w_rdata[0] = w_en[i];
            end
            if (i_cfg_addr == 8'(i * STRIDE) + PDATA_LO_OFFSET) begin
                w_pd64  = 64'(w_pdata[i]);
                w_rdata = w_pd64[31:0];
            end
            if (DATA_WIDTH == 64 && i_cfg_addr == 8'(i * STRIDE) + PDATA_HI_OFFSET) begin
                w_pd64  = 64'(w_pdata[i]);
                w_rdata = w_pd64[63:32];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cfg_rvalid <= 1'b0;
            r_cfg_rdata  <= '0;
        end else begin
            r_cfg_rvalid <= i_cfg_req;
            r_cfg_rdata  <= (i_cfg_req && !i_cfg_we) ? w_rdata : '0;
        end
    end

    assign o_cfg_rvalid = r_cfg_rvalid;
    assign o_cfg_rdata  = r_cfg_rdata;

    // Scanning downwards lets the lowest matching index overwrite the others.
    always_comb begin
        w_hit  = 1'b0;
        w_data = '0;
        for (int i = int'(NUM_PATCH) - 1; i >= 0; i--) begin
            if (w_en[i] && w_waddr[i] == i_widx) begin
                w_hit  = 1'b1;
                w_data = w_pdata[i];
            end
        end
    end

    assign o_hit  = w_hit & ~i_test_mode;
    assign o_data = w_data;

endmodule

// File: rtl/boot_rom_patch.sv
// Boot ROM slave: req/gnt/rvalid port, patch override after the ROM register,
// then RD_LATENCY output register stages.
module boot_rom_patch
    import boot_rom_patch_pkg::*;
#(
    parameter int unsigned ROM_ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_PATCH      = 4,
    parameter int unsigned RD_LATENCY     = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  init_ni,
    input  logic                  test_mode_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [31:0]           addr_i,
    output logic                  gnt_o,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    input  logic                  cfg_req_i,
    input  logic                  cfg_we_i,
    input  logic [7:0]            cfg_addr_i,
    input  logic [31:0]           cfg_wdata_i,
    output logic [31:0]           cfg_rdata_o,
    output logic                  cfg_rvalid_o
);

    localparam int unsigned BYTE_BITS = $clog2(DATA_WIDTH / 8);
    localparam int unsigned WIDX_W    = ROM_ADDR_WIDTH - BYTE_BITS;

    logic [WIDX_W-1:0]     w_widx;
    logic                  w_unused_addr;
    logic                  w_rd;
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_patch_data;
    logic [DATA_WIDTH-1:0] w_rom_data;
    logic [DATA_WIDTH-1:0] w_s0_data;

    logic                  r_s0_valid;
    logic                  r_s0_err;
    logic                  r_s0_hit;
    logic [DATA_WIDTH-1:0] r_s0_pdata;
    logic [DATA_WIDTH-1:0] r_rom_q;

    logic                  w_pv [RD_LATENCY+1];
    logic                  w_pe [RD_LATENCY+1];
    logic [DATA_WIDTH-1:0] w_pd [RD_LATENCY+1];

    // Upper address bits alias the window; byte lane bits carry no meaning here.
    assign w_widx        = addr_i[ROM_ADDR_WIDTH-1:BYTE_BITS];
    assign w_unused_addr = ^{addr_i[31:ROM_ADDR_WIDTH], addr_i[BYTE_BITS-1:0]};

    assign gnt_o = req_i & init_ni;
    assign w_rd  = gnt_o & ~we_i;

    boot_rom_patch_table #(
        .ROM_ADDR_WIDTH (ROM_ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .NUM_PATCH      (NUM_PATCH),
        .WIDX_W         (WIDX_W)
    ) u_table (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .i_cfg_req    (cfg_req_i),
        .i_cfg_we     (cfg_we_i),
        .i_cfg_addr   (cfg_addr_i),
        .i_cfg_wdata  (cfg_wdata_i),
        .o_cfg_rdata  (cfg_rdata_o),
        .o_cfg_rvalid (cfg_rvalid_o),
        .i_widx       (w_widx),
        .i_test_mode  (test_mode_i),
        .o_hit        (w_hit),
        .o_data       (w_patch_data)
    );

    generate
        if (DATA_WIDTH == 64) begin : g_rom64
            assign w_rom_data = {rom_word32(16'({w_widx, 1'b1})), rom_word32(16'({w_widx, 1'b0}))};
        end else begin : g_rom32
            assign w_rom_data = rom_word32(16'(w_widx));
        end
    endgenerate

    // ROM register is only enabled for legal reads; the patch hit and its data
    // are captured with the request so later config writes cannot leak in.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s0_valid <= 1'b0;
            r_s0_err   <= 1'b0;
            r_s0_hit   <= 1'b0;
            r_s0_pdata <= '0;
            r_rom_q    <= '0;
        end else begin
            r_s0_valid <= gnt_o;
            r_s0_err   <= gnt_o & we_i;
            r_s0_hit   <= w_rd & w_hit;
            if (w_rd) begin
                r_rom_q    <= w_rom_data;
                r_s0_pdata <= w_patch_data;
            end
        end
    end

    always_comb begin
        w_s0_data = '0;
        if (r_s0_valid && !r_s0_err) begin
            w_s0_data = r_s0_hit ? r_s0_pdata : r_rom_q;
        end
    end

    assign w_pv[0] = r_s0_valid;
    assign w_pe[0] = r_s0_err;
    assign w_pd[0] = w_s0_data;

    genvar gi;
    generate
        for (gi = 1; gi <= RD_LATENCY; gi++) begin : g_pipe
            logic                  r_v;
            logic                  r_e;
            logic [DATA_WIDTH-1:0] r_d;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_v <= 1'b0;
                    r_e <= 1'b0;
                    r_d <= '0;
                end else begin
                    r_v <= w_pv[gi-1];
                    r_e <= w_pe[gi-1];
                    r_d <= w_pd[gi-1];
                end
            end
            assign w_pv[gi] = r_v;
            assign w_pe[gi] = r_e;
            assign w_pd[gi] = r_d;
        end
    endgenerate

    assign rvalid_o = w_pv[RD_LATENCY];
    assign err_o    = w_pe[RD_LATENCY];
    assign rdata_o  = w_pd[RD_LATENCY];

endmodule
